gfx256_renderer: RTL and testbench
==================================

Name: gfx256_renderer

Overview:
- Final pixel stage, directly downstream of the alpha blender.
- Accepts one pixel or one 256-bit strip per handshake and computes its framebuffer byte address, lane select and replicated write data.
- Optionally performs a 16-bit depth test against a Z-buffer using a read, compare and conditional Z-write.
- Issues 256-bit write requests to the wishbone master writer, then acknowledges the blender.

Parameters:
- point_width, 16, width of the x/y/z coordinates.
- MDW, 256, memory data width in bits; only 256 is supported (32 byte lanes).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- target_base_i  in  32  framebuffer byte base, 32-byte aligned
- target_size_x_i  in  point_width  framebuffer width in pixels
- color_depth_i  in  2  0=8bpp, 1=16bpp, 2=32bpp; 3 is reserved and treated as 32bpp
- zbuffer_enable_i  in  1  enable depth test
- zbuffer_base_i  in  32  Z-buffer byte base, 32-byte aligned, 16 bits per entry
- pixel_x_i, pixel_y_i  in  point_width  pixel coordinates
- pixel_z_i  in  point_width  signed depth
- pixel_color_i  in  32  pixel colour, right-justified
- strip_i  in  1  strip write; whole 256-bit word
- strip_color_i  in  256  strip data
- write_i  in  1  pixel valid; held high until ack_o
- ack_o  out  1  one-cycle completion pulse
- wbm_write_request_o  out  1  write request
- wbm_write_addr_o  out  32  word address, bits [4:0] = 0
- wbm_write_sel_o  out  32  byte enables
- wbm_write_data_o  out  256  write data
- wbm_write_ack_i  in  1  write done
- zbuf_read_request_o  out  1  Z read request
- zbuf_addr_o  out  32  Z word address, bits [4:0] = 0
- zbuf_data_i  in  256  Z read data, valid with ack
- zbuf_ack_i  in  1  Z read done

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - ack_o, both request outputs, and all address/sel/data outputs = 0.
- A reset mid-transaction abandons any outstanding request; the arbiter drops it.
- States: IDLE, CALC, ZREAD, ZWRITE, CWRITE, ACK.
- IDLE:
  - On write_i=1, register the coordinates, colour, strip flag, strip data, depth mode and zbuffer_enable_i, then go to CALC.
  - Inputs are not re-sampled until the next IDLE.
- CALC (1 cycle), registered arithmetic:
  - p = y*size_x + x, 32-bit unsigned, wraps modulo 2^32.
  - coff = p << color_depth (3 treated as 2); zoff = p << 1.
  - caddr = target_base + coff; zaddr = zbuffer_base + zoff.
  - clane = caddr[4:0]; zlane = zaddr[4:0].
- Colour sel = {1, 3, F}[depth] << clane.
- Colour data = colour[7:0] x32, colour[15:0] x16, or colour[31:0] x8.
- Transitions out of CALC:
  - strip: sel = 32'hFFFFFFFF, data = strip_color, go to CWRITE. The depth test is bypassed.
  - else if Z enabled: go to ZREAD.
  - else: go to CWRITE.
- ZREAD:
  - zbuf_read_request_o=1 with zbuf_addr_o = zaddr & ~31.
  - On zbuf_ack_i: drop the request and extract stored = zbuf_data_i[zlane*8 +: 16].
  - Signed compare: if pixel_z < stored, go to ZWRITE; else go to ACK with no memory writes.
- ZWRITE:
  - Write zaddr & ~31, sel = 3 << zlane, data = {16{pixel_z}}.
  - On wbm_write_ack_i, go to CWRITE.
- CWRITE:
  - Write caddr & ~31 with the colour sel and data.
  - On wbm_write_ack_i, go to ACK.
- Request rules:
  - A request rises on state entry and stays high until its ack cycle; it deasserts on the edge that samples the ack.
  - Address, sel and data are stable while a request is high.
  - An ack arriving with no request pending is ignored.
- ACK: ack_o=1 for exactly one cycle, then IDLE. write_i is ignored during ACK.
- Latency, no Z: write_i accept → CALC → CWRITE request 2 cycles after accept → ack_o 1 cycle after wbm_write_ack_i.
- Latency, Z pass: adds the read plus a Z write. Z fail: ack_o 1 cycle after zbuf_ack_i.
- Equal depth fails the test; only strictly nearer pixels are written.

Decomposition:
- gfx256_pkg gains:
  - renderer_state_e, the 3-bit enum.
  - Colour-depth constants CD8/CD16/CD32.
  - Function fnReplicateColor(depth, color) → 256-bit data.
  - Function fnLaneSel(depth, lane) → 32-bit sel.
- One natural sub-module: gfx256_pixel_addr, the registered CALC-stage address/lane/sel generator. It is shared by the colour and Z paths.

Test Plan:
1. Base 0x00100000, width 640, x=3, y=2, 16bpp, colour 0x1234, Z off → addr 0x00100A00, sel 0x000000C0, data {16{16'h1234}}; ack_o one cycle after wbm_write_ack_i.
2. Same pixel with Z on, zbase 0x00200000, z=100, zbuf_data_i[63:48]=200 → Z read at 0x00200A00; Z write sel 0x000000C0, data {16{16'd100}}; then the colour write and ack.
3. Same with stored z=50, then stored z=100 → no wbm_write_request_o; ack_o the cycle after zbuf_ack_i.
4. Strip, 8bpp, x=40, y=0, base 0 → addr 0x00000020, sel 0xFFFFFFFF, data = strip_color_i; no Z read even with Z on.
5. 32bpp, x=7, y=0, base 0 → addr 0, sel 0xF0000000; hold wbm_write_ack_i low for 10 cycles → request, addr, sel and data all stable throughout.
6. Assert rst_i during ZREAD → request and ack_o fall immediately (asynchronously); next write_i is serviced from IDLE normally.

Source files
------------

// File: rtl/gfx256_pkg.sv
// Shared types, colour-depth codes and lane/replication helpers for the
// gfx256 final pixel stage.
package gfx256_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_ZREAD  = 3'd2,
    S_ZWRITE = 3'd3,
    S_CWRITE = 3'd4,
    S_ACK    = 3'd5
  } renderer_state_e;

  localparam logic [1:0] CD8  = 2'd0;
  localparam logic [1:0] CD16 = 2'd1;
  localparam logic [1:0] CD32 = 2'd2;

  // Code 3 is reserved and behaves exactly like 32bpp.
  function automatic logic [1:0] fnNormDepth(input logic [1:0] depth);
    return (depth == 2'd3) ? CD32 : depth;
  endfunction

  function automatic logic [255:0] fnReplicateColor(input logic [1:0] depth,
                                                     input logic [31:0] color);
    logic [255:0] data;
    case (depth)
      CD8:     data = {32{color[7:0]}};
      CD16:    data = {16{color[15:0]}};
      default: data = {8{color}};
    endcase
    return data;
  endfunction

  function automatic logic [31:0] fnLaneSel(input logic [1:0] depth,
                                            input logic [4:0] lane);
    logic [31:0] base;
    case (depth)
      CD8:     base = 32'h0000_0001;
      CD16:    base = 32'h0000_0003;
      default: base = 32'h0000_000F;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/gfx256_pixel_addr.sv
// Registered CALC-stage generator: linear pixel index, colour and Z byte
// addresses, and the byte-lane selects for both paths.
module gfx256_pixel_addr #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   calc_i,
  input  logic [31:0]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [31:0]            zbuffer_base_i,
  input  logic [1:0]             depth_i,
  input  logic [point_width-1:0] x_i,
  input  logic [point_width-1:0] y_i,
  output logic [31:0]            caddr_o,
  output logic [31:0]            zaddr_o,
  output logic [4:0]             zlane_o,
  output logic [31:0]            csel_o,
  output logic [31:0]            zsel_o
);
  import gfx256_pkg::*;

  logic [31:0] pix;
  logic [31:0] caddr_d, caddr_q;
  logic [31:0] zaddr_d, zaddr_q;
  logic [31:0] csel_d, csel_q;
  logic [31:0] zsel_d, zsel_q;

  // Index arithmetic is deliberately 32-bit and wraps, matching the bus space.
  always_comb begin
    pix     = 32'(y_i) * 32'(target_size_x_i) + 32'(x_i);
    caddr_d = caddr_q;
    zaddr_d = zaddr_q;
    csel_d  = csel_q;
    zsel_d  = zsel_q;
    if (calc_i) begin
      caddr_d = target_base_i + (pix << depth_i);
      zaddr_d = zbuffer_base_i + (pix << 1);
      csel_d  = fnLaneSel(depth_i, caddr_d[4:0]);
      zsel_d  = 32'h0000_0003 << zaddr_d[4:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      caddr_q <= '0;
      zaddr_q <= '0;
      csel_q  <= '0;
      zsel_q  <= '0;
    end else begin
      caddr_q <= caddr_d;
      zaddr_q <= zaddr_d;
      csel_q  <= csel_d;
      zsel_q  <= zsel_d;
    end
  end

  assign caddr_o = {caddr_q[31:5], 5'b00000};
  assign zaddr_o = {zaddr_q[31:5], 5'b00000};
  assign zlane_o = zaddr_q[4:0];
  assign csel_o  = csel_q;
  assign zsel_o  = zsel_q;

endmodule

// File: rtl/gfx256_renderer.sv
// Final pixel stage: optional 16-bit depth test against the Z-buffer, then a
// 256-bit framebuffer write, then a one-cycle acknowledge to the blender.
module gfx256_renderer #(
  parameter int point_width = 16,
  parameter int MDW         = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [1:0]             color_depth_i,
  input  logic                   zbuffer_enable_i,
  input  logic [31:0]            zbuffer_base_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [31:0]            pixel_color_i,
  input  logic                   strip_i,
  input  logic [MDW-1:0]         strip_color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  output logic                   wbm_write_request_o,
  output logic [31:0]            wbm_write_addr_o,
  output logic [31:0]            wbm_write_sel_o,
  output logic [MDW-1:0]         wbm_write_data_o,
  input  logic                   wbm_write_ack_i,
  output logic                   zbuf_read_request_o,
  output logic [31:0]            zbuf_addr_o,
  input  logic [MDW-1:0]         zbuf_data_i,
  input  logic                   zbuf_ack_i
);
  import gfx256_pkg::*;

  renderer_state_e state_d, state_q;

  logic [point_width-1:0] x_d, x_q, y_d, y_q, z_d, z_q;
  logic [31:0]            color_d, color_q;
  logic                   strip_d, strip_q, zen_d, zen_q;
  logic [MDW-1:0]         sdata_d, sdata_q;
  logic [1:0]             depth_d, depth_q;

  logic        load;
  logic [31:0] caddr, zaddr, csel, zsel;
  logic [4:0]  zlane;
  logic [15:0] z_stored;

  gfx256_pixel_addr #(.point_width(point_width)) u_pixel_addr (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .calc_i          (state_q == S_CALC),
    .target_base_i   (target_base_i),
    .target_size_x_i (target_size_x_i),
    .zbuffer_base_i  (zbuffer_base_i),
    .depth_i         (depth_q),
    .x_i             (x_q),
    .y_i             (y_q),
    .caddr_o         (caddr),
    .zaddr_o         (zaddr),
    .zlane_o         (zlane),
    .csel_o          (csel),
    .zsel_o          (zsel)
  );

  assign load     = (state_q == S_IDLE) && write_i;
  assign z_stored = zbuf_data_i[{zlane, 3'b000} +: 16];

  // Pixel fields are captured once at accept and held for the whole transaction.
  always_comb begin
    x_d     = load ? pixel_x_i : x_q;
    y_d     = load ? pixel_y_i : y_q;
    z_d     = load ? pixel_z_i : z_q;
    color_d = load ? pixel_color_i : color_q;
    strip_d = load ? strip_i : strip_q;
    sdata_d = load ? strip_color_i : sdata_q;
    depth_d = load ? fnNormDepth(color_depth_i) : depth_q;
    zen_d   = load ? zbuffer_enable_i : zen_q;
  end

  // Equal depth fails: only strictly nearer pixels reach the Z write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (write_i) state_d = S_CALC;
      S_CALC:   state_d = (strip_q || !zen_q) ? S_CWRITE : S_ZREAD;
      S_ZREAD:  if (zbuf_ack_i)
                  state_d = ($signed(z_q[15:0]) < $signed(z_stored)) ? S_ZWRITE : S_ACK;
      S_ZWRITE: if (wbm_write_ack_i) state_d = S_CWRITE;
      S_CWRITE: if (wbm_write_ack_i) state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      color_q <= '0;
      strip_q <= 1'b0;
      sdata_q <= '0;
      depth_q <= CD8;
      zen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      color_q <= color_d;
      strip_q <= strip_d;
      sdata_q <= sdata_d;
      depth_q <= depth_d;
      zen_q   <= zen_d;
    end
  end

  // Requests decode straight from state so a reset drops them without a clock.
  always_comb begin
    ack_o               = (state_q == S_ACK);
    zbuf_read_request_o = (state_q == S_ZREAD);
    zbuf_addr_o         = zbuf_read_request_o ? zaddr : 32'h0;
    wbm_write_request_o = 1'b0;
    wbm_write_addr_o    = 32'h0;
    wbm_write_sel_o     = 32'h0;
    wbm_write_data_o    = '0;
    case (state_q)
      S_ZWRITE: begin
        wbm_write_request_o = 1'b1;
        wbm_write_addr_o    = zaddr;
        wbm_write_sel_o     = zsel;
        wbm_write_data_o    = {16{z_q[15:0]}};
      end
      S_CWRITE: begin
        wbm_write_request_o = 1'b1;
        wbm_write_addr_o    = caddr;
        wbm_write_sel_o     = strip_q ? 32'hFFFF_FFFF : csel;
        wbm_write_data_o    = strip_q ? sdata_q : fnReplicateColor(depth_q, color_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gfx256_renderer.sv
// Scoreboard bench for gfx256_renderer: a byte-level reference model queues the
// expected bus events and a monitor pops and compares them as the DUT emits them.
module tb_gfx256_renderer;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  target_base_i = '0;
  logic [15:0]  target_size_x_i = '0;
  logic [1:0]   color_depth_i = '0;
  logic         zbuffer_enable_i = 1'b0;
  logic [31:0]  zbuffer_base_i = '0;
  logic [15:0]  pixel_x_i = '0, pixel_y_i = '0, pixel_z_i = '0;
  logic [31:0]  pixel_color_i = '0;
  logic         strip_i = 1'b0;
  logic [255:0] strip_color_i = '0;
  logic         write_i = 1'b0;
  logic         ack_o;
  logic         wbm_write_request_o;
  logic [31:0]  wbm_write_addr_o, wbm_write_sel_o;
  logic [255:0] wbm_write_data_o;
  logic         wbm_write_ack_i = 1'b0;
  logic         zbuf_read_request_o;
  logic [31:0]  zbuf_addr_o;
  logic [255:0] zbuf_data_i = '0;
  logic         zbuf_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  gfx256_renderer #(.point_width(16), .MDW(256)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .target_base_i       (target_base_i),
    .target_size_x_i     (target_size_x_i),
    .color_depth_i       (color_depth_i),
    .zbuffer_enable_i    (zbuffer_enable_i),
    .zbuffer_base_i      (zbuffer_base_i),
    .pixel_x_i           (pixel_x_i),
    .pixel_y_i           (pixel_y_i),
    .pixel_z_i           (pixel_z_i),
    .pixel_color_i       (pixel_color_i),
    .strip_i             (strip_i),
    .strip_color_i       (strip_color_i),
    .write_i             (write_i),
    .ack_o               (ack_o),
    .wbm_write_request_o (wbm_write_request_o),
    .wbm_write_addr_o    (wbm_write_addr_o),
    .wbm_write_sel_o     (wbm_write_sel_o),
    .wbm_write_data_o    (wbm_write_data_o),
    .wbm_write_ack_i     (wbm_write_ack_i),
    .zbuf_read_request_o (zbuf_read_request_o),
    .zbuf_addr_o         (zbuf_addr_o),
    .zbuf_data_i         (zbuf_data_i),
    .zbuf_ack_i          (zbuf_ack_i)
  );

  localparam int EV_ZRD = 0;
  localparam int EV_WR  = 1;
  localparam int EV_ACK = 2;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [31:0]  sel;
    logic [255:0] data;
  } ev_t;

  typedef struct {
    logic [31:0]  base;
    logic [15:0]  width;
    logic [15:0]  x, y;
    logic [1:0]   depth;
    logic         zen;
    logic [31:0]  zbase;
    logic [15:0]  z;
    logic [31:0]  color;
    logic         strip;
    logic [255:0] sdata;
    logic [15:0]  stored;
  } pix_t;

  ev_t          exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           resp_cyc = -100;
  int           issue_cyc = 0;
  bit           first_pending = 1'b0;
  logic [255:0] cur_zdata = '0;
  bit           zr_hold = 1'b0;
  bit           stray_wr = 1'b0;
  int           zr_wait = 0;
  int           wr_wait = 0;

  always @(posedge clk_i) cyc++;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Write-side slave: acks after a per-request wait; can also inject an ack with nothing pending.
  always begin
    @(posedge clk_i);
    #2;
    wbm_write_ack_i = 1'b0;
    if (stray_wr && !wbm_write_request_o) begin
      wbm_write_ack_i = 1'b1;
      stray_wr = 1'b0;
    end else if (wbm_write_request_o && !rst_i) begin
      if (wr_wait == 0) begin
        wbm_write_ack_i = 1'b1;
        wr_wait = $urandom_range(0, 3);
      end else begin
        wr_wait--;
      end
    end
  end

  // Z-read slave: the stored depth is only presented together with the ack.
  always begin
    @(posedge clk_i);
    #2;
    zbuf_ack_i  = 1'b0;
    zbuf_data_i = rand256();
    if (zbuf_read_request_o && !zr_hold && !rst_i) begin
      if (zr_wait == 0) begin
        zbuf_ack_i  = 1'b1;
        zbuf_data_i = cur_zdata;
        zr_wait = $urandom_range(0, 3);
      end else begin
        zr_wait--;
      end
    end
  end

  initial begin : monitor
    bit  prev_wr, prev_wr_ack, prev_zr, prev_zr_ack;
    ev_t cur_wr, e;
    prev_wr = 0; prev_wr_ack = 0; prev_zr = 0; prev_zr_ack = 0;
    cur_wr = '{kind: EV_WR, addr: '0, sel: '0, data: '0};
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_wr = 0; prev_wr_ack = 0; prev_zr = 0; prev_zr_ack = 0;
        continue;
      end
      if (zbuf_read_request_o && (!prev_zr || prev_zr_ack)) begin
        if (exp_q.size() == 0) checkOutput("unexpected_zread", 1, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("zread_kind", e.kind, EV_ZRD);
          checkOutput("zread_addr", zbuf_addr_o, e.addr);
          if (first_pending) begin
            checkOutput("zread_latency", cyc - issue_cyc, 2);
            first_pending = 0;
          end
        end
      end
      if (wbm_write_request_o) begin
        if (!prev_wr || prev_wr_ack) begin
          if (exp_q.size() == 0) checkOutput("unexpected_write", 1, 0);
          else begin
            cur_wr = exp_q.pop_front();
            checkOutput("write_kind", cur_wr.kind, EV_WR);
            if (first_pending) begin
              checkOutput("write_latency", cyc - issue_cyc, 2);
              first_pending = 0;
            end
          end
        end
        checkOutput("write_addr", wbm_write_addr_o, cur_wr.addr);
        checkOutput("write_sel", wbm_write_sel_o, cur_wr.sel);
        checkOutput("write_data", wbm_write_data_o, cur_wr.data);
      end
      if (ack_o) begin
        if (exp_q.size() == 0) checkOutput("unexpected_ack", 1, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("ack_kind", e.kind, EV_ACK);
          checkOutput("ack_latency", cyc - resp_cyc, 1);
        end
      end
      prev_zr     = zbuf_read_request_o;
      prev_zr_ack = zbuf_read_request_o && zbuf_ack_i;
      prev_wr     = wbm_write_request_o;
      prev_wr_ack = wbm_write_request_o && wbm_write_ack_i;
      if (prev_zr_ack || prev_wr_ack) resp_cyc = cyc;
    end
  end

  // Reference model: byte addresses and byte lanes straight from pixel geometry.
  task automatic modelPixel(input pix_t px, output logic [31:0] zaddr);
    logic [31:0]  p, caddr;
    int           nbytes, clane, zlane;
    ev_t          ev;
    bit           pass;
    p      = 32'(px.y) * 32'(px.width) + 32'(px.x);
    nbytes = (px.depth == 2'd0) ? 1 : (px.depth == 2'd1) ? 2 : 4;
    caddr  = px.base + p * nbytes;
    zaddr  = px.zbase + p * 2;
    clane  = int'(caddr % 32);
    zlane  = int'(zaddr % 32);
    cur_zdata = rand256();
    cur_zdata[zlane*8 +: 16] = px.stored;
    pass = 1'b1;
    if (!px.strip && px.zen) begin
      exp_q.push_back('{kind: EV_ZRD, addr: zaddr - zlane, sel: '0, data: '0});
      pass = $signed(px.z) < $signed(px.stored);
      if (pass) begin
        ev = '{kind: EV_WR, addr: zaddr - zlane, sel: '0, data: '0};
        ev.sel[zlane] = 1'b1;
        ev.sel[zlane+1] = 1'b1;
        for (int i = 0; i < 32; i++) ev.data[i*8 +: 8] = 8'(px.z >> (8 * (i % 2)));
        exp_q.push_back(ev);
      end
    end
    if (pass) begin
      ev = '{kind: EV_WR, addr: caddr - clane, sel: '0, data: '0};
      if (px.strip) begin
        ev.sel  = 32'hFFFF_FFFF;
        ev.data = px.sdata;
      end else begin
        for (int b = 0; b < nbytes; b++) ev.sel[clane+b] = 1'b1;
        for (int i = 0; i < 32; i++) ev.data[i*8 +: 8] = 8'(px.color >> (8 * (i % nbytes)));
      end
      exp_q.push_back(ev);
    end
    exp_q.push_back('{kind: EV_ACK, addr: '0, sel: '0, data: '0});
  endtask

  task automatic driveInputs(input pix_t px);
    target_base_i    = px.base;
    target_size_x_i  = px.width;
    color_depth_i    = px.depth;
    zbuffer_enable_i = px.zen;
    zbuffer_base_i   = px.zbase;
    pixel_x_i        = px.x;
    pixel_y_i        = px.y;
    pixel_z_i        = px.z;
    pixel_color_i    = px.color;
    strip_i          = px.strip;
    strip_color_i    = px.sdata;
  endtask

  task automatic applyStimulus(input pix_t px, input int wdelay);
    logic [31:0] zaddr;
    bit          got;
    @(posedge clk_i);
    #1;
    modelPixel(px, zaddr);
    if (wdelay >= 0) wr_wait = wdelay;
    driveInputs(px);
    write_i = 1'b1;
    issue_cyc = cyc;
    first_pending = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk_i);
      if (ack_o) got = 1'b1;
    end
    if (!got) begin
      checkOutput("ack_timeout", 0, 1);
      exp_q.delete();
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
    end
    @(posedge clk_i);
    #1;
    write_i = 1'b0;
  endtask

  task automatic resetMidZread(input pix_t px);
    logic [31:0] zaddr;
    int          n;
    @(posedge clk_i);
    #1;
    zr_hold = 1'b1;
    modelPixel(px, zaddr);
    void'(exp_q.pop_back());
    driveInputs(px);
    write_i = 1'b1;
    issue_cyc = cyc;
    first_pending = 1'b1;
    n = 0;
    while (!zbuf_read_request_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("zread_before_reset", zbuf_read_request_o, 1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("reset_zread_req", zbuf_read_request_o, 0);
    checkOutput("reset_zbuf_addr", zbuf_addr_o, 0);
    checkOutput("reset_ack", ack_o, 0);
    checkOutput("reset_write_req", wbm_write_request_o, 0);
    write_i = 1'b0;
    exp_q.delete();
    first_pending = 1'b0;
    zr_hold = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  function automatic pix_t randPixel();
    pix_t px;
    px.base   = $urandom & 32'hFFFF_FFE0;
    px.width  = 16'($urandom_range(1, 1023));
    px.x      = 16'($urandom_range(0, int'(px.width) - 1));
    px.y      = 16'($urandom_range(0, 511));
    px.depth  = 2'($urandom_range(0, 3));
    px.zen    = 1'($urandom_range(0, 1));
    px.zbase  = $urandom & 32'hFFFF_FFE0;
    px.z      = 16'($urandom);
    px.color  = $urandom;
    px.strip  = ($urandom_range(0, 5) == 0);
    px.sdata  = rand256();
    case ($urandom_range(0, 3))
      0:       px.stored = px.z;
      1:       px.stored = px.z + 16'd1;
      default: px.stored = 16'($urandom);
    endcase
    return px;
  endfunction

  initial begin : stimulus
    pix_t px;
    #1 rst_i = 1'b1;
    #2;
    checkOutput("reset_ack_o", ack_o, 0);
    checkOutput("reset_wbm_req", wbm_write_request_o, 0);
    checkOutput("reset_zbuf_req", zbuf_read_request_o, 0);
    checkOutput("reset_wbm_addr", wbm_write_addr_o, 0);
    checkOutput("reset_wbm_sel", wbm_write_sel_o, 0);
    checkOutput("reset_wbm_data", wbm_write_data_o, 0);
    checkOutput("reset_zbuf_addr", zbuf_addr_o, 0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    px = '{base: 32'h0010_0000, width: 16'd640, x: 16'd3, y: 16'd2, depth: 2'd1,
           zen: 1'b0, zbase: 32'h0020_0000, z: 16'd100, color: 32'h0000_1234,
           strip: 1'b0, sdata: '0, stored: 16'd200};
    applyStimulus(px, -1);
    px.zen = 1'b1;
    applyStimulus(px, -1);
    px.stored = 16'd50;
    applyStimulus(px, -1);
    px.stored = 16'd100;
    applyStimulus(px, -1);

    px = '{base: 32'h0, width: 16'd640, x: 16'd40, y: 16'd0, depth: 2'd0,
           zen: 1'b1, zbase: 32'h0020_0000, z: 16'd5, color: 32'hAB,
           strip: 1'b1, sdata: rand256(), stored: 16'd1};
    applyStimulus(px, -1);

    px = '{base: 32'h0, width: 16'd640, x: 16'd7, y: 16'd0, depth: 2'd2,
           zen: 1'b0, zbase: 32'h0, z: 16'd0, color: 32'hDEAD_BEEF,
           strip: 1'b0, sdata: '0, stored: 16'd0};
    applyStimulus(px, 10);

    px = randPixel();
    px.zen = 1'b1;
    px.strip = 1'b0;
    resetMidZread(px);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        stray_wr = 1'b1;
        repeat (3) @(posedge clk_i);
      end
      applyStimulus(randPixel(), -1);
    end

    repeat (4) @(negedge clk_i);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
